// File: rtl/reg_arbiter_pkg.sv
// rtl/reg_arbiter_pkg.sv - shared state encoding and width helper for reg_arbiter
package reg_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Index width for n requesters, never less than one bit.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or above ptr, wrapping
module rr_pick
    import reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            found_o,
    output logic [IW-1:0]   idx_o
);

    int j;

    // Walk offsets downward so the smallest offset from ptr is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - shared register with round-robin capture and bounded lock ownership
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int MAXHOLD   = 4,
    parameter int IW        = clog2w(NREQ)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           lock,
    input  logic [NREQ*DATAWIDTH-1:0] d,
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      q,
    output logic                      q_valid,
    output logic [IW-1:0]             q_src
);

    state_e                state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [3:0]            hold_q, hold_d;
    logic [DATAWIDTH-1:0]  q_q, q_d;
    logic [IW-1:0]         src_q, src_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic                  qv_q, qv_d;

    logic                  found;
    logic [IW-1:0]         pick;
    logic                  cap;
    logic [IW-1:0]         cap_idx;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (pick)
    );

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
    endfunction

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            q_q     <= '0;
            src_q   <= '0;
            gnt_q   <= '0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
            src_q   <= src_d;
            gnt_q   <= gnt_d;
            qv_q    <= qv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        cap     = 1'b0;
        cap_idx = owner_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    cap     = 1'b1;
                    cap_idx = pick;
                    if (lock[pick]) begin
                        state_d = OWN;
                        owner_d = pick;
                        hold_d  = 4'd1;
                    end else begin
                        ptr_d = next_idx(pick);
                    end
                end
            end
            OWN: begin
                // An exhausted or idle owner releases without capturing; a dropped lock still gets its last word.
                if (!req[owner_q] || hold_q == 4'(MAXHOLD)) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                    hold_d  = '0;
                end else if (!lock[owner_q]) begin
                    cap     = 1'b1;
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                    hold_d  = '0;
                end else begin
                    cap    = 1'b1;
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_d   = q_q;
        src_d = src_q;
        gnt_d = '0;
        qv_d  = cap;
        if (cap) begin
            q_d            = d[cap_idx*DATAWIDTH +: DATAWIDTH];
            src_d          = cap_idx;
            gnt_d[cap_idx] = 1'b1;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = qv_q;
    assign q_src   = src_q;

endmodule
